// File: rtl/qdr_multiport_arbiter_if.sv
// Client-side request/return bus and controller-side user bus of the QDR port arbiter.
// No latency of its own; it only bundles signals.
// Backpressure: none here. Clients hold strobes until p_ack, and read issue is gated by rd_outstanding.
interface qdr_multiport_arbiter_if #(
    parameter int NUM_PORTS  = 4,
    parameter int ADDR_WIDTH = 22,
    parameter int DATA_WIDTH = 36,
    parameter int BE_WIDTH   = 4,
    parameter int TAG_DEPTH  = 16
) ();
    localparam int CW = $clog2(TAG_DEPTH + 1);

    logic                            phy_rdy;
    logic [NUM_PORTS*ADDR_WIDTH-1:0] p_addr;
    logic [NUM_PORTS-1:0]            p_wr_strb;
    logic [NUM_PORTS*DATA_WIDTH-1:0] p_wr_data;
    logic [NUM_PORTS*BE_WIDTH-1:0]   p_wr_be;
    logic [NUM_PORTS-1:0]            p_rd_strb;
    logic [NUM_PORTS-1:0]            p_ack;
    logic [DATA_WIDTH-1:0]           p_rd_data;
    logic [NUM_PORTS-1:0]            p_rd_dvld;
    logic [ADDR_WIDTH-1:0]           usr_addr;
    logic                            usr_wr_strb;
    logic [DATA_WIDTH-1:0]           usr_wr_data;
    logic [BE_WIDTH-1:0]             usr_wr_be;
    logic                            usr_rd_strb;
    logic [DATA_WIDTH-1:0]           usr_rd_data;
    logic                            usr_rd_dvld;
    logic [CW-1:0]                   rd_outstanding;
    logic                            tag_err;

    modport master (
        output phy_rdy, p_addr, p_wr_strb, p_wr_data, p_wr_be, p_rd_strb,
               usr_rd_data, usr_rd_dvld,
        input  p_ack, p_rd_data, p_rd_dvld, usr_addr, usr_wr_strb, usr_wr_data,
               usr_wr_be, usr_rd_strb, rd_outstanding, tag_err
    );

    modport slave (
        input  phy_rdy, p_addr, p_wr_strb, p_wr_data, p_wr_be, p_rd_strb,
               usr_rd_data, usr_rd_dvld,
        output p_ack, p_rd_data, p_rd_dvld, usr_addr, usr_wr_strb, usr_wr_data,
               usr_wr_be, usr_rd_strb, rd_outstanding, tag_err
    );
endinterface

// File: rtl/qdr_multiport_arbiter.sv
// Round-robin share of one QDR controller user port among NUM_PORTS clients, with a tag FIFO that routes reads home.
// Latency: ack is combinational, the command is issued 1 cycle after the ack, and read data is returned 1 cycle after usr_rd_dvld.
// Backpressure: no grants while phy_rdy is low; reads are held off while TAG_DEPTH reads are outstanding.
module qdr_multiport_arbiter #(
    parameter int NUM_PORTS  = 4,
    parameter int ADDR_WIDTH = 22,
    parameter int DATA_WIDTH = 36,
    parameter int BE_WIDTH   = 4,
    parameter int TAG_DEPTH  = 16
) (
    input  logic                   clk0,
    input  logic                   reset_n,
    qdr_multiport_arbiter_if.slave bus
);
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int TW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int CW = $clog2(TAG_DEPTH + 1);

    logic [NUM_PORTS-1:0]  elig;
    logic                  rd_room;
    logic                  gnt_vld;
    logic [PW-1:0]         gnt_idx;
    logic [PW-1:0]         cand;
    int                    cand_i;
    logic                  gnt_wr;
    logic                  push;
    logic                  pop;

    logic [PW-1:0]         ptr_q;
    logic                  usr_wr_strb_q;
    logic                  usr_rd_strb_q;
    logic [ADDR_WIDTH-1:0] usr_addr_q;
    logic [DATA_WIDTH-1:0] usr_wr_data_q;
    logic [BE_WIDTH-1:0]   usr_wr_be_q;
    logic [PW-1:0]         tag_mem_q [TAG_DEPTH];
    logic [TW-1:0]         wr_ptr_q;
    logic [TW-1:0]         rd_ptr_q;
    logic [CW-1:0]         cnt_q;
    logic [CW-1:0]         cnt_d;
    logic [NUM_PORTS-1:0]  p_rd_dvld_q;
    logic [DATA_WIDTH-1:0] p_rd_data_q;
    logic                  tag_err_q;

    assign rd_room = (cnt_q < CW'(TAG_DEPTH));

    // A held read never blocks a write from the same port; the write always goes first.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            elig[i] = bus.p_wr_strb[i] || (bus.p_rd_strb[i] && rd_room);
        end
        if (!bus.phy_rdy || !reset_n) begin
            elig = '0;
        end
    end

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand_i  = 0;
        cand    = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            cand_i = int'(ptr_q) + k;
            if (cand_i >= NUM_PORTS) begin
                cand_i = cand_i - NUM_PORTS;
            end
            cand = PW'(cand_i);
            if (!gnt_vld && elig[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    assign gnt_wr = bus.p_wr_strb[gnt_idx];
    assign push   = gnt_vld && !gnt_wr;
    assign pop    = bus.usr_rd_dvld && (cnt_q != '0);

    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (pop && !push) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk0 or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q         <= PW'(NUM_PORTS - 1);
            usr_wr_strb_q <= 1'b0;
            usr_rd_strb_q <= 1'b0;
            usr_addr_q    <= '0;
            usr_wr_data_q <= '0;
            usr_wr_be_q   <= '0;
        end else begin
            usr_wr_strb_q <= gnt_vld && gnt_wr;
            usr_rd_strb_q <= push;
            if (gnt_vld) begin
                ptr_q      <= gnt_idx;
                usr_addr_q <= bus.p_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
                if (gnt_wr) begin
                    usr_wr_data_q <= bus.p_wr_data[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
                    usr_wr_be_q   <= bus.p_wr_be[gnt_idx*BE_WIDTH +: BE_WIDTH];
                end
            end
        end
    end

    // Returns arrive in issue order, so the FIFO head always names the owner.
    always_ff @(posedge clk0 or negedge reset_n) begin
        if (!reset_n) begin
            for (int j = 0; j < TAG_DEPTH; j++) begin
                tag_mem_q[j] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            p_rd_dvld_q <= '0;
            p_rd_data_q <= '0;
            tag_err_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            p_rd_dvld_q <= '0;
            if (push) begin
                tag_mem_q[wr_ptr_q] <= gnt_idx;
                wr_ptr_q            <= wr_ptr_q + TW'(1);
            end
            if (pop) begin
                rd_ptr_q    <= rd_ptr_q + TW'(1);
                p_rd_dvld_q <= NUM_PORTS'(1) << tag_mem_q[rd_ptr_q];
                p_rd_data_q <= bus.usr_rd_data;
            end
            if (bus.usr_rd_dvld && (cnt_q == '0)) begin
                tag_err_q <= 1'b1;
            end
        end
    end

    assign bus.p_ack          = gnt_vld ? (NUM_PORTS'(1) << gnt_idx) : '0;
    assign bus.usr_wr_strb    = usr_wr_strb_q;
    assign bus.usr_rd_strb    = usr_rd_strb_q;
    assign bus.usr_addr       = usr_addr_q;
    assign bus.usr_wr_data    = usr_wr_data_q;
    assign bus.usr_wr_be      = usr_wr_be_q;
    assign bus.p_rd_dvld      = p_rd_dvld_q;
    assign bus.p_rd_data      = p_rd_data_q;
    assign bus.rd_outstanding = cnt_q;
    assign bus.tag_err        = tag_err_q;
endmodule

// File: tb/tb_qdr_multiport_arbiter.sv
// Bench for qdr_multiport_arbiter: random and directed client traffic plus an in-order controller model,
// with a queue-based reference model that is compared against the DUT at every falling edge.
module tb_qdr_multiport_arbiter;
    localparam int N  = 4;
    localparam int AW = 22;
    localparam int DW = 36;
    localparam int BW = 4;
    localparam int TD = 16;

    logic clk0 = 1'b0;
    logic reset_n;
    always #5 clk0 = ~clk0;

    qdr_multiport_arbiter_if #(.NUM_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .TAG_DEPTH(TD)) bus ();
    qdr_multiport_arbiter #(.NUM_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .TAG_DEPTH(TD)) dut (
        .clk0(clk0), .reset_n(reset_n), .bus(bus));

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    // client-side stimulus state
    logic [N-1:0]  c_wr, c_rd, auto_wr, auto_rd;
    logic [AW-1:0] c_addr [N];
    logic [DW-1:0] c_wdat [N];
    logic [BW-1:0] c_be   [N];
    bit rand_req, rand_phy, p_rdy;

    // controller-side model: reads return in issue order
    typedef struct packed { int due; logic [DW-1:0] dat; } ret_t;
    ret_t ret_q[$];
    logic [DW-1:0] mem [logic [AW-1:0]];
    int  ret_lat, ret_budget, last_due;
    bit  ret_rand, spur;

    // reference model state
    int            m_ptr;
    int            m_tags[$];
    logic          m_wr_strb, m_rd_strb, m_tag_err;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdat, m_rdata;
    logic [BW-1:0] m_be;
    logic [N-1:0]  m_dvld, m_ack_vec;

    // observation logs of the DUT
    int           ack_port_log[$];
    int           ack_cyc_log[$];
    logic [N-1:0] ret_vec_log[$];
    logic [DW-1:0] ret_dat_log[$];
    int           ret_cyc_log[$];
    int           iss_kind_log[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
        return {a[13:0], a} ^ 36'h5_A5A5_A5A5;
    endfunction

    function automatic int count_port(input int p);
        int n = 0;
        foreach (ack_port_log[j]) if (ack_port_log[j] == p) n++;
        return n;
    endfunction

    always @(negedge clk0) begin : cmp
        int g;
        int idx;
        int lat;
        logic [N-1:0] exp_ack;
        logic [DW-1:0] rdat;
        if (!reset_n) begin
            chk("rst_p_ack", 64'(bus.p_ack), 64'(0));
            chk("rst_usr_wr_strb", 64'(bus.usr_wr_strb), 64'(0));
            chk("rst_usr_rd_strb", 64'(bus.usr_rd_strb), 64'(0));
            chk("rst_usr_addr", 64'(bus.usr_addr), 64'(0));
            chk("rst_p_rd_dvld", 64'(bus.p_rd_dvld), 64'(0));
            chk("rst_p_rd_data", 64'(bus.p_rd_data), 64'(0));
            chk("rst_rd_outstanding", 64'(bus.rd_outstanding), 64'(0));
            chk("rst_tag_err", 64'(bus.tag_err), 64'(0));
            m_ptr = N - 1;
            m_tags.delete();
            m_wr_strb = 0; m_rd_strb = 0; m_tag_err = 0;
            m_addr = '0; m_wdat = '0; m_be = '0; m_dvld = '0; m_rdata = '0;
            m_ack_vec = '0;
            last_due = 0;
        end else begin
            g = -1;
            if (bus.phy_rdy) begin
                for (int k = 1; k <= N; k++) begin
                    idx = (m_ptr + k) % N;
                    if (g < 0 && (bus.p_wr_strb[idx] || (bus.p_rd_strb[idx] && m_tags.size() < TD))) g = idx;
                end
            end
            exp_ack = (g >= 0) ? (N'(1) << g) : '0;
            chk("p_ack", 64'(bus.p_ack), 64'(exp_ack));
            chk("usr_wr_strb", 64'(bus.usr_wr_strb), 64'(m_wr_strb));
            chk("usr_rd_strb", 64'(bus.usr_rd_strb), 64'(m_rd_strb));
            chk("usr_addr", 64'(bus.usr_addr), 64'(m_addr));
            chk("usr_wr_data", 64'(bus.usr_wr_data), 64'(m_wdat));
            chk("usr_wr_be", 64'(bus.usr_wr_be), 64'(m_be));
            chk("p_rd_dvld", 64'(bus.p_rd_dvld), 64'(m_dvld));
            chk("p_rd_data", 64'(bus.p_rd_data), 64'(m_rdata));
            chk("rd_outstanding", 64'(bus.rd_outstanding), 64'(m_tags.size()));
            chk("tag_err", 64'(bus.tag_err), 64'(m_tag_err));

            for (int i = 0; i < N; i++) begin
                if (bus.p_ack[i]) begin ack_port_log.push_back(i); ack_cyc_log.push_back(cyc); end
            end
            if (bus.p_rd_dvld != '0) begin
                ret_vec_log.push_back(bus.p_rd_dvld);
                ret_dat_log.push_back(bus.p_rd_data);
                ret_cyc_log.push_back(cyc);
            end
            if (bus.usr_wr_strb) iss_kind_log.push_back(1);
            if (bus.usr_rd_strb) iss_kind_log.push_back(2);

            // next clock edge
            m_dvld = '0;
            if (bus.usr_rd_dvld) begin
                if (m_tags.size() == 0) m_tag_err = 1'b1;
                else begin
                    m_dvld  = N'(1) << m_tags.pop_front();
                    m_rdata = bus.usr_rd_data;
                end
            end
            m_wr_strb = 1'b0;
            m_rd_strb = 1'b0;
            if (g >= 0) begin
                m_addr = bus.p_addr[g*AW +: AW];
                if (bus.p_wr_strb[g]) begin
                    m_wr_strb = 1'b1;
                    m_wdat = bus.p_wr_data[g*DW +: DW];
                    m_be   = bus.p_wr_be[g*BW +: BW];
                    mem[m_addr] = m_wdat;
                end else begin
                    m_rd_strb = 1'b1;
                    m_tags.push_back(g);
                    lat  = ret_rand ? int'($urandom_range(1, 12)) : ret_lat;
                    rdat = mem.exists(m_addr) ? mem[m_addr] : dflt(m_addr);
                    if (cyc + 1 + lat <= last_due) last_due = last_due + 1;
                    else last_due = cyc + 1 + lat;
                    ret_q.push_back('{due: last_due, dat: rdat});
                end
                m_ptr = g;
            end
            m_ack_vec = exp_ack;
        end
        cyc++;
    end

    task automatic new_write(input int i);
        c_wr[i]   = 1'b1;
        c_addr[i] = AW'($urandom_range(0, 255));
        c_wdat[i] = DW'({$urandom(), $urandom()});
        c_be[i]   = BW'($urandom());
    endtask

    task automatic new_read(input int i);
        c_rd[i]   = 1'b1;
        c_addr[i] = AW'($urandom_range(0, 255));
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bus.p_addr[i*AW +: AW]    = c_addr[i];
            bus.p_wr_data[i*DW +: DW] = c_wdat[i];
            bus.p_wr_be[i*BW +: BW]   = c_be[i];
        end
        bus.p_wr_strb = c_wr;
        bus.p_rd_strb = c_rd;
        bus.phy_rdy   = p_rdy;
    endtask

    task automatic tick();
        int kind;
        @(posedge clk0);
        #1;
        for (int i = 0; i < N; i++) begin
            if (m_ack_vec[i]) begin
                if (c_wr[i]) begin
                    c_wr[i] = 1'b0;
                    if (auto_wr[i]) new_write(i);
                end else begin
                    c_rd[i] = 1'b0;
                    if (auto_rd[i]) new_read(i);
                end
            end
        end
        if (rand_req) begin
            for (int i = 0; i < N; i++) begin
                if (!c_wr[i] && !c_rd[i] && $urandom_range(0, 2) == 0) begin
                    kind = int'($urandom_range(0, 3));
                    if (kind <= 1) new_write(i);
                    else if (kind == 2) new_read(i);
                    else begin new_write(i); c_rd[i] = 1'b1; end
                end
            end
        end
        if (rand_phy) p_rdy = ($urandom_range(0, 7) != 0);
        bus.usr_rd_dvld = 1'b0;
        if (spur) begin
            bus.usr_rd_dvld = 1'b1;
            bus.usr_rd_data = DW'({$urandom(), $urandom()});
            spur = 1'b0;
        end else if (ret_budget != 0 && ret_q.size() > 0 && ret_q[0].due <= cyc) begin
            ret_t r;
            r = ret_q.pop_front();
            bus.usr_rd_dvld = 1'b1;
            bus.usr_rd_data = r.dat;
            if (ret_budget > 0) ret_budget--;
        end
        drive();
    endtask

    task automatic wait_idle(input string nm, input int budget);
        int n = 0;
        while ((c_wr | c_rd) != '0 && n < budget) begin tick(); n++; end
        chk({nm, "_idle_timeout"}, 64'(c_wr | c_rd), 64'(0));
    endtask

    task automatic wait_drain(input string nm, input int budget);
        int n = 0;
        while ((m_tags.size() != 0 || ret_q.size() != 0) && n < budget) begin tick(); n++; end
        tick(); tick();
        chk({nm, "_drain_rd_outstanding"}, 64'(bus.rd_outstanding), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset_n = 1'b0;
        c_wr = '0; c_rd = '0; auto_wr = '0; auto_rd = '0;
        for (int i = 0; i < N; i++) begin c_addr[i] = '0; c_wdat[i] = '0; c_be[i] = '0; end
        rand_req = 0; rand_phy = 0; p_rdy = 0; spur = 0;
        ret_lat = 4; ret_rand = 0; ret_budget = -1; last_due = 0;
        m_ack_vec = '0;
        bus.usr_rd_dvld = 1'b0;
        bus.usr_rd_data = '0;
        drive();
        tick(); tick(); tick();
        reset_n = 1'b1;
        p_rdy = 1'b1;

        // all four ports stream writes: strict rotation from port 0
        ack_port_log.delete();
        for (int i = 0; i < N; i++) new_write(i);
        auto_wr = '1;
        drive();
        repeat (8) tick();
        auto_wr = '0;
        wait_idle("t1", 20);
        chk("t1_ack_count", 64'(ack_port_log.size() >= 8), 64'(1));
        if (ack_port_log.size() >= 8) begin
            int exp_order [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
            for (int j = 0; j < 8; j++) chk($sformatf("t1_ack_order_%0d", j), 64'(ack_port_log[j]), 64'(exp_order[j]));
        end

        // single read from port 2 returning after 10 cycles
        mem[22'h1A5] = 36'h9_ABCD_1234;
        ret_lat = 10;
        ack_cyc_log.delete(); ret_vec_log.delete(); ret_dat_log.delete(); ret_cyc_log.delete();
        c_rd[2] = 1'b1; c_addr[2] = 22'h1A5;
        drive();
        wait_idle("t2", 10);
        n = 0;
        while (ret_vec_log.size() == 0 && n < 40) begin tick(); n++; end
        chk("t2_returned", 64'(ret_vec_log.size()), 64'(1));
        if (ret_vec_log.size() > 0 && ack_cyc_log.size() > 0) begin
            chk("t2_dvld_vec", 64'(ret_vec_log[0]), 64'(4'b0100));
            chk("t2_rd_data", 64'(ret_dat_log[0]), 64'(36'h9_ABCD_1234));
            chk("t2_latency", 64'(ret_cyc_log[0] - ack_cyc_log[0]), 64'(12));
        end
        wait_drain("t2", 40);

        // tag FIFO saturation: port 1 reads with no returns, port 0 writes
        ret_budget = 0;
        ack_port_log.delete();
        new_read(1); auto_rd[1] = 1'b1;
        new_write(0); auto_wr[0] = 1'b1;
        drive();
        repeat (45) tick();
        chk("t3_port1_acks", 64'(count_port(1)), 64'(16));
        chk("t3_outstanding_full", 64'(bus.rd_outstanding), 64'(16));
        ack_port_log.delete();
        repeat (5) tick();
        chk("t3_port1_blocked", 64'(count_port(1)), 64'(0));
        chk("t3_port0_served", 64'(count_port(0)), 64'(5));
        ack_port_log.delete();
        ret_budget = 1;
        repeat (6) tick();
        chk("t3_one_more_read", 64'(count_port(1)), 64'(1));
        chk("t3_outstanding_refull", 64'(bus.rd_outstanding), 64'(16));
        auto_rd = '0; auto_wr = '0;
        ret_budget = -1;
        wait_idle("t3", 60);
        wait_drain("t3", 80);

        // both strobes on port 3: write first, read on a later grant
        ack_port_log.delete(); iss_kind_log.delete();
        new_write(3); c_rd[3] = 1'b1;
        drive();
        wait_idle("t4", 10);
        tick(); tick();
        chk("t4_port3_acks", 64'(count_port(3)), 64'(2));
        chk("t4_issue_count", 64'(iss_kind_log.size()), 64'(2));
        if (iss_kind_log.size() >= 2) begin
            chk("t4_first_is_write", 64'(iss_kind_log[0]), 64'(1));
            chk("t4_second_is_read", 64'(iss_kind_log[1]), 64'(2));
        end
        wait_drain("t4", 40);

        // reads from ports 0, 3, 1 returned back-to-back
        ret_budget = 0;
        begin
            int order [3] = '{0, 3, 1};
            for (int j = 0; j < 3; j++) begin
                new_read(order[j]);
                drive();
                wait_idle("t5", 10);
            end
        end
        repeat (15) tick();
        ret_vec_log.delete(); ret_cyc_log.delete(); ret_dat_log.delete();
        ret_budget = -1;
        n = 0;
        while (ret_vec_log.size() < 3 && n < 20) begin tick(); n++; end
        chk("t5_returns", 64'(ret_vec_log.size()), 64'(3));
        if (ret_vec_log.size() >= 3) begin
            chk("t5_dvld_0", 64'(ret_vec_log[0]), 64'(4'b0001));
            chk("t5_dvld_1", 64'(ret_vec_log[1]), 64'(4'b1000));
            chk("t5_dvld_2", 64'(ret_vec_log[2]), 64'(4'b0010));
            chk("t5_gap_01", 64'(ret_cyc_log[1] - ret_cyc_log[0]), 64'(1));
            chk("t5_gap_12", 64'(ret_cyc_log[2] - ret_cyc_log[1]), 64'(1));
        end
        wait_drain("t5", 40);

        // random traffic with random return latency and phy_rdy dropouts
        rand_req = 1; rand_phy = 1; ret_rand = 1;
        repeat (600) tick();
        rand_req = 0; rand_phy = 0; p_rdy = 1'b1;
        wait_idle("rand", 100);
        wait_drain("rand", 200);
        ret_rand = 0;

        // no acks while phy_rdy is low
        p_rdy = 1'b0;
        ack_port_log.delete();
        for (int i = 0; i < N; i++) new_write(i);
        drive();
        repeat (10) tick();
        chk("t6_no_ack_phy_low", 64'(ack_port_log.size()), 64'(0));
        p_rdy = 1'b1;
        drive();
        wait_idle("t6", 20);

        // reset pulsed mid-burst with reads outstanding, then a spurious return
        ret_budget = 0;
        rand_req = 1;
        repeat (20) tick();
        reset_n = 1'b0;
        #1;
        chk("t6_rst_p_ack", 64'(bus.p_ack), 64'(0));
        chk("t6_rst_usr_strb", 64'({bus.usr_wr_strb, bus.usr_rd_strb}), 64'(0));
        chk("t6_rst_p_rd_dvld", 64'(bus.p_rd_dvld), 64'(0));
        chk("t6_rst_outstanding", 64'(bus.rd_outstanding), 64'(0));
        chk("t6_rst_tag_err", 64'(bus.tag_err), 64'(0));
        rand_req = 0;
        c_wr = '0; c_rd = '0;
        ret_q.delete();
        bus.usr_rd_dvld = 1'b0;
        drive();
        tick(); tick();
        reset_n = 1'b1;
        ret_budget = -1;
        tick();
        spur = 1'b1;
        tick();
        tick(); tick();
        chk("t6_tag_err_set", 64'(bus.tag_err), 64'(1));
        chk("t6_spur_no_dvld", 64'(bus.p_rd_dvld), 64'(0));
        chk("t6_spur_outstanding", 64'(bus.rd_outstanding), 64'(0));
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
